// File: rtl/display_pkg.sv
// Shared types and glyph constants for the multi-digit seven-segment driver.
// Glyphs are stored active-high (bit0=a ... bit6=g); the output stage applies polarity.
package display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_ENCODE
  } state_e;

  localparam int unsigned NIBBLE_W = 4;

  localparam logic [6:0] GLYPH_0     = 7'h3F;
  localparam logic [6:0] GLYPH_1     = 7'h06;
  localparam logic [6:0] GLYPH_2     = 7'h5B;
  localparam logic [6:0] GLYPH_3     = 7'h4F;
  localparam logic [6:0] GLYPH_4     = 7'h66;
  localparam logic [6:0] GLYPH_5     = 7'h6D;
  localparam logic [6:0] GLYPH_6     = 7'h7D;
  localparam logic [6:0] GLYPH_7     = 7'h07;
  localparam logic [6:0] GLYPH_8     = 7'h7F;
  localparam logic [6:0] GLYPH_9     = 7'h6F;
  localparam logic [6:0] GLYPH_A     = 7'h77;
  localparam logic [6:0] GLYPH_B     = 7'h7C;
  localparam logic [6:0] GLYPH_C     = 7'h39;
  localparam logic [6:0] GLYPH_D     = 7'h5E;
  localparam logic [6:0] GLYPH_E     = 7'h79;
  localparam logic [6:0] GLYPH_F     = 7'h71;
  localparam logic [6:0] GLYPH_DASH  = 7'h40;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  // One nibble per digit plus a single carry-catch bit on top.
  function automatic int unsigned bcd_width(input int unsigned n_digits);
    return NIBBLE_W * n_digits + 1;
  endfunction

endpackage

// File: rtl/seg7_glyph.sv
// Combinational 4-bit value to active-high seven-segment glyph.
module seg7_glyph
  import display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] glyph_o
);

  always_comb begin
    glyph_o = GLYPH_BLANK;
    unique case (nibble_i)
      4'h0: glyph_o = GLYPH_0;
      4'h1: glyph_o = GLYPH_1;
      4'h2: glyph_o = GLYPH_2;
      4'h3: glyph_o = GLYPH_3;
      4'h4: glyph_o = GLYPH_4;
      4'h5: glyph_o = GLYPH_5;
      4'h6: glyph_o = GLYPH_6;
      4'h7: glyph_o = GLYPH_7;
      4'h8: glyph_o = GLYPH_8;
      4'h9: glyph_o = GLYPH_9;
      4'hA: glyph_o = GLYPH_A;
      4'hB: glyph_o = GLYPH_B;
      4'hC: glyph_o = GLYPH_C;
      4'hD: glyph_o = GLYPH_D;
      4'hE: glyph_o = GLYPH_E;
      4'hF: glyph_o = GLYPH_F;
      default: glyph_o = GLYPH_BLANK;
    endcase
  end

endmodule

// File: rtl/display_7s_multi.sv
// Multi-digit seven-segment driver: sequential double-dabble (decimal) or direct
// nibbles (hex), with leading-zero blanking, overflow dashes and atomic update.
module display_7s_multi
  import display_pkg::*;
#(
  parameter int unsigned N_DIGITS   = 4,
  parameter int unsigned IN_WIDTH   = 14,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IN_WIDTH-1:0]   valor,
  input  logic                  modo,
  input  logic                  blank_zeros,
  input  logic                  inicio,
  output logic                  ocupado,
  output logic                  pronto,
  output logic                  overflow,
  output logic [7*N_DIGITS-1:0] saida
);

  localparam int unsigned BCD_W = bcd_width(N_DIGITS);
  localparam int unsigned HEX_W = NIBBLE_W * N_DIGITS;
  localparam int unsigned PAD_W = (IN_WIDTH > HEX_W) ? IN_WIDTH : HEX_W;
  localparam int unsigned CNT_W = $clog2(IN_WIDTH + 1);
  localparam logic [6:0]  POL   = ACTIVE_LOW ? 7'h7F : 7'h00;

  state_e               state_q;
  logic [IN_WIDTH-1:0]  val_q;
  logic                 modo_q;
  logic                 blank_q;
  logic [BCD_W-1:0]     bcd_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 ocupado_q;
  logic                 pronto_q;
  logic                 ovf_q;
  logic [7*N_DIGITS-1:0] saida_q;

  logic [HEX_W-1:0]     bcd_adj;
  logic [BCD_W-1:0]     bcd_step;
  logic [PAD_W-1:0]     val_pad;
  logic                 hex_ovf;
  logic                 ovf_d;
  logic [3:0]           nib   [N_DIGITS];
  logic [6:0]           glyph [N_DIGITS];
  logic [N_DIGITS-1:0]  lead_zero;
  logic [7*N_DIGITS-1:0] saida_d;

  // Double-dabble step; the top bit is sticky so values far above the
  // representable range still flag overflow after their carry shifts past it.
  always_comb begin
    bcd_adj = '0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      bcd_adj[NIBBLE_W*i +: NIBBLE_W] = (bcd_q[NIBBLE_W*i +: NIBBLE_W] >= 4'd5)
        ? bcd_q[NIBBLE_W*i +: NIBBLE_W] + 4'd3
        : bcd_q[NIBBLE_W*i +: NIBBLE_W];
    end
    bcd_step = {bcd_q[BCD_W-1] | bcd_adj[HEX_W-1], bcd_adj[HEX_W-2:0], val_q[IN_WIDTH-1]};
  end

  always_comb begin
    val_pad = '0;
    val_pad[IN_WIDTH-1:0] = val_q;
    hex_ovf = 1'b0;
    for (int unsigned k = HEX_W; k < PAD_W; k++) begin
      hex_ovf = hex_ovf | val_pad[k];
    end
    ovf_d = modo_q ? hex_ovf : bcd_q[BCD_W-1];
  end

  always_comb begin
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      nib[i] = modo_q ? val_pad[NIBBLE_W*i +: NIBBLE_W] : bcd_q[NIBBLE_W*i +: NIBBLE_W];
    end
  end

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_glyph
    seg7_glyph u_glyph (
      .nibble_i (nib[g]),
      .glyph_o  (glyph[g])
    );
  end

  // Scan from the most significant digit down; digit 0 always stays visible.
  always_comb begin
    logic        seen;
    int unsigned idx;
    seen      = 1'b0;
    idx       = 0;
    lead_zero = '0;
    for (int unsigned k = 0; k < N_DIGITS; k++) begin
      idx            = N_DIGITS - 1 - k;
      seen           = seen | (nib[idx] != 4'd0);
      lead_zero[idx] = !seen && (idx != 0);
    end
  end

  always_comb begin
    saida_d = '0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (ovf_d) begin
        saida_d[7*i +: 7] = GLYPH_DASH ^ POL;
      end else if (blank_q && lead_zero[i]) begin
        saida_d[7*i +: 7] = GLYPH_BLANK ^ POL;
      end else begin
        saida_d[7*i +: 7] = glyph[i] ^ POL;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      val_q     <= '0;
      modo_q    <= 1'b0;
      blank_q   <= 1'b0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      ocupado_q <= 1'b0;
      pronto_q  <= 1'b0;
      ovf_q     <= 1'b0;
      saida_q   <= {N_DIGITS{GLYPH_BLANK ^ POL}};
    end else begin
      pronto_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (inicio) begin
            val_q     <= valor;
            modo_q    <= modo;
            blank_q   <= blank_zeros;
            bcd_q     <= '0;
            cnt_q     <= '0;
            ocupado_q <= 1'b1;
            state_q   <= modo ? ST_ENCODE : ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          bcd_q <= bcd_step;
          val_q <= val_q << 1;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(IN_WIDTH - 1)) begin
            state_q <= ST_ENCODE;
          end
        end
        ST_ENCODE: begin
          saida_q   <= saida_d;
          ovf_q     <= ovf_d;
          pronto_q  <= 1'b1;
          ocupado_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ocupado  = ocupado_q;
  assign pronto   = pronto_q;
  assign overflow = ovf_q;
  assign saida    = saida_q;

endmodule

// File: tb/tb_display_7s_multi.sv
// Randomized and directed bench for display_7s_multi against an arithmetic reference model.
module tb_display_7s_multi;

  localparam int unsigned N_DIGITS = 4;
  localparam int unsigned IN_WIDTH = 14;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [IN_WIDTH-1:0]   valor = '0;
  logic                  modo = 1'b0;
  logic                  blank_zeros = 1'b0;
  logic                  inicio = 1'b0;
  logic                  ocupado;
  logic                  pronto;
  logic                  overflow;
  logic [7*N_DIGITS-1:0] saida;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [6:0] LOW_CODE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  display_7s_multi #(
    .N_DIGITS   (N_DIGITS),
    .IN_WIDTH   (IN_WIDTH),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .valor       (valor),
    .modo        (modo),
    .blank_zeros (blank_zeros),
    .inicio      (inicio),
    .ocupado     (ocupado),
    .pronto      (pronto),
    .overflow    (overflow),
    .saida       (saida)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // Reference: digits from division (decimal) or shifts (hex), then display rules.
  function automatic logic [27:0] model(input int v, input bit m, input bit bz, output bit ovf);
    int d [4];
    int pow;
    int msd;
    logic [27:0] res;
    ovf = m ? (v >= 65536) : (v >= 10000);
    if (ovf) return {4{7'h3F}};
    pow = 1;
    for (int i = 0; i < 4; i++) begin
      d[i] = m ? ((v >> (4 * i)) & 15) : ((v / pow) % 10);
      pow  = pow * 10;
    end
    msd = 0;
    for (int i = 0; i < 4; i++) if (d[i] != 0) msd = i;
    res = '0;
    for (int i = 0; i < 4; i++) res[7*i +: 7] = (bz && i > msd) ? 7'h7F : LOW_CODE[d[i]];
    return res;
  endfunction

  task automatic start(input int v, input bit m, input bit bz);
    valor       = IN_WIDTH'(v);
    modo        = m;
    blank_zeros = bz;
    inicio      = 1'b1;
    @(posedge clk);
    #1;
    inicio = 1'b0;
  endtask

  task automatic wait_done(output int lat, output bit busy_ok);
    lat     = 0;
    busy_ok = 1'b1;
    while (pronto !== 1'b1 && lat < 100) begin
      if (ocupado !== 1'b1) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic verify(input int v, input bit m, input bit bz, input string tag);
    bit          eovf;
    logic [27:0] exp;
    exp = model(v, m, bz, eovf);
    chk({tag, ".saida"}, 64'(saida), 64'(exp));
    chk({tag, ".ovf"}, 64'(overflow), 64'(eovf));
  endtask

  task automatic run(input int v, input bit m, input bit bz, input string tag);
    int          lat;
    bit          busy_ok;
    bit          eovf;
    logic [27:0] exp;
    start(v, m, bz);
    wait_done(lat, busy_ok);
    chk({tag, ".lat"}, 64'(lat), m ? 64'd1 : 64'(IN_WIDTH + 1));
    chk({tag, ".busy"}, 64'(busy_ok), 64'd1);
    chk({tag, ".idle"}, 64'(ocupado), 64'd0);
    verify(v, m, bz, tag);
    exp = model(v, m, bz, eovf);
    @(posedge clk);
    #1;
    chk({tag, ".pulse"}, 64'(pronto), 64'd0);
    chk({tag, ".hold"}, 64'(saida), 64'(exp));
  endtask

  initial begin
    int lat;
    bit busy_ok;
    int pulses;
    int v;
    bit m;
    bit bz;

    #12;
    chk("rst.saida", 64'(saida), 64'h0FFF_FFFF);
    chk("rst.flags", 64'({ocupado, pronto, overflow}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run(1234, 1'b0, 1'b0, "dec1234");
    run(7, 1'b0, 1'b1, "dec7bz");
    run(0, 1'b0, 1'b1, "dec0bz");
    run(12345 % 16384, 1'b0, 1'b0, "dec_ovf");
    run(9999, 1'b0, 1'b0, "dec9999");
    run(10000, 1'b0, 1'b0, "dec10000");
    run(16383, 1'b0, 1'b1, "decmax");
    run('h2AF, 1'b1, 1'b0, "hex2AF");
    run('h2AF, 1'b1, 1'b1, "hex2AFbz");
    run(0, 1'b1, 1'b1, "hex0bz");
    run('h3FFF, 1'b1, 1'b0, "hexmax");

    // inicio during SHIFT must be ignored
    start(1234, 1'b0, 1'b0);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    valor  = IN_WIDTH'(5);
    inicio = 1'b1;
    @(posedge clk);
    #1;
    inicio = 1'b0;
    wait_done(lat, busy_ok);
    chk("ign.lat", 64'(lat), 64'd10);
    verify(1234, 1'b0, 1'b0, "ign");
    pulses = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (pronto === 1'b1) pulses++;
    end
    chk("ign.extra", 64'(pulses), 64'd0);

    // inicio on the pronto cycle is accepted immediately
    start(321, 1'b0, 1'b1);
    wait_done(lat, busy_ok);
    start(58, 1'b0, 1'b0);
    chk("b2b.busy", 64'(ocupado), 64'd1);
    wait_done(lat, busy_ok);
    chk("b2b.lat", 64'(lat), 64'(IN_WIDTH + 1));
    verify(58, 1'b0, 1'b0, "b2b");
    @(posedge clk);
    #1;

    // asynchronous reset in the middle of SHIFT
    start(1234, 1'b0, 1'b0);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst = 1'b1;
    #1;
    chk("arst.saida", 64'(saida), 64'h0FFF_FFFF);
    chk("arst.flags", 64'({ocupado, pronto, overflow}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (pronto === 1'b1 || ocupado === 1'b1) pulses++;
    end
    chk("arst.quiet", 64'(pulses), 64'd0);
    run(42, 1'b0, 1'b0, "after_rst42");

    for (int unsigned i = 0; i < 40; i++) begin
      v  = int'($urandom_range(0, 16383));
      m  = 1'($urandom);
      bz = 1'($urandom);
      if (i % 4 == 0) v = int'($urandom_range(0, 99));
      run(v, m, bz, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
